// File: rtl/wb_pipe_reg_if.sv
// Write-back pipeline register bus: the stage controls, the incoming write-back
// slot and the registered stage contents with their action/counter observers.
`timescale 1ns/1ps

interface wb_pipe_reg_if #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int NCH     = 2,
  parameter int STALL_W = 6,
  parameter int CNT_W   = 16
);
  // Pipeline control
  logic [STALL_W-1:0]    stall;
  logic                  flush;
  logic                  cnt_clr;

  // Upstream write-back slot
  logic                  in_valid;
  logic [NCH-1:0]        in_we;
  logic [NCH*ADDR_W-1:0] in_addr;
  logic [NCH*DATA_W-1:0] in_data;
  logic                  in_whilo;
  logic [DATA_W-1:0]     in_hi;
  logic [DATA_W-1:0]     in_lo;
  logic                  in_llbit_we;
  logic                  in_llbit_val;

  // Registered stage contents
  logic                  out_valid;
  logic [NCH-1:0]        out_we;
  logic [NCH*ADDR_W-1:0] out_addr;
  logic [NCH*DATA_W-1:0] out_data;
  logic                  out_whilo;
  logic [DATA_W-1:0]     out_hi;
  logic [DATA_W-1:0]     out_lo;
  logic                  out_llbit_we;
  logic                  out_llbit_val;

  // Action / statistics observers
  logic [1:0]            last_op;
  logic [CNT_W-1:0]      bubble_cnt;
  logic [CNT_W-1:0]      hold_cnt;

  // Producer side: drives controls and the incoming slot
  modport master (
    output stall, flush, cnt_clr,
    output in_valid, in_we, in_addr, in_data, in_whilo, in_hi, in_lo,
    output in_llbit_we, in_llbit_val,
    input  out_valid, out_we, out_addr, out_data, out_whilo, out_hi, out_lo,
    input  out_llbit_we, out_llbit_val,
    input  last_op, bubble_cnt, hold_cnt
  );

  // Pipeline register side
  modport slave (
    input  stall, flush, cnt_clr,
    input  in_valid, in_we, in_addr, in_data, in_whilo, in_hi, in_lo,
    input  in_llbit_we, in_llbit_val,
    output out_valid, out_we, out_addr, out_data, out_whilo, out_hi, out_lo,
    output out_llbit_we, out_llbit_val,
    output last_op, bubble_cnt, hold_cnt
  );
endinterface

// File: rtl/wb_pipe_reg.sv
// Write-back pipeline register between two stages. Each edge applies exactly
// one action (FLUSH > BUBBLE > HOLD > LOAD), records it in last_op, and counts
// bubbles and holds in saturating counters. STAGE must not exceed STALL_W-2.
`timescale 1ns/1ps

module wb_pipe_reg #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int NCH     = 2,
  parameter int STALL_W = 6,
  parameter int STAGE   = 4,
  parameter int CNT_W   = 16
) (
  input logic          clk,
  input logic          rst_n,
  wb_pipe_reg_if.slave bus
);

  typedef enum logic [1:0] {
    OP_LOAD   = 2'd0,
    OP_HOLD   = 2'd1,
    OP_BUBBLE = 2'd2,
    OP_FLUSH  = 2'd3
  } op_e;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  op_e  w_op;
  logic w_kill;   // stage is overwritten with reset values
  logic w_take;   // stage samples the upstream slot
  logic w_live;   // upstream slot carries a real instruction

  // Only our own stall bit and the downstream one matter; the rest of the
  // vector belongs to other stages.
  logic w_unused_stall;
  assign w_unused_stall = ^bus.stall;

  // Action decode: flush beats every stall combination
  always_comb begin
    w_op = OP_LOAD;
    if (bus.flush)
      w_op = OP_FLUSH;
    else if (bus.stall[STAGE])
      w_op = bus.stall[STAGE+1] ? OP_HOLD : OP_BUBBLE;
  end

  assign w_kill = (w_op == OP_FLUSH) || (w_op == OP_BUBBLE);
  assign w_take = (w_op == OP_LOAD);
  assign w_live = bus.in_valid;

  logic              r_valid;
  logic              r_whilo;
  logic [DATA_W-1:0] r_hi;
  logic [DATA_W-1:0] r_lo;
  logic              r_llbit_we;
  logic              r_llbit_val;
  op_e               r_last_op;
  logic [CNT_W-1:0]  r_bubble_cnt;
  logic [CNT_W-1:0]  r_hold_cnt;

  // Shared stage fields; an invalid slot is loaded as a clean NOP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid     <= 1'b0;
      r_whilo     <= 1'b0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_llbit_we  <= 1'b0;
      r_llbit_val <= 1'b0;
    end else if (w_kill) begin
      r_valid     <= 1'b0;
      r_whilo     <= 1'b0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_llbit_we  <= 1'b0;
      r_llbit_val <= 1'b0;
    end else if (w_take) begin
      r_valid     <= w_live;
      r_whilo     <= w_live & bus.in_whilo;
      r_hi        <= w_live ? bus.in_hi : '0;
      r_lo        <= w_live ? bus.in_lo : '0;
      r_llbit_we  <= w_live & bus.in_llbit_we;
      r_llbit_val <= w_live & bus.in_llbit_val;
    end
  end

  // Per-channel GPR write-back fields
  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;

    // Channel gi stage register, same action rules as the shared fields
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_we   <= 1'b0;
        r_addr <= '0;
        r_data <= '0;
      end else if (w_kill) begin
        r_we   <= 1'b0;
        r_addr <= '0;
        r_data <= '0;
      end else if (w_take) begin
        r_we   <= w_live & bus.in_we[gi];
        r_addr <= w_live ? bus.in_addr[gi*ADDR_W +: ADDR_W] : '0;
        r_data <= w_live ? bus.in_data[gi*DATA_W +: DATA_W] : '0;
      end
    end

    assign bus.out_we[gi]                     = r_we;
    assign bus.out_addr[gi*ADDR_W +: ADDR_W]  = r_addr;
    assign bus.out_data[gi*DATA_W +: DATA_W]  = r_data;
  end

  // Remember which action was applied at the latest edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_last_op <= OP_LOAD;
    else
      r_last_op <= w_op;
  end

  // Saturating bubble/hold counters; clear wins over a same-cycle increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bubble_cnt <= '0;
      r_hold_cnt   <= '0;
    end else if (bus.cnt_clr) begin
      r_bubble_cnt <= '0;
      r_hold_cnt   <= '0;
    end else begin
      if (w_op == OP_BUBBLE && r_bubble_cnt != CNT_MAX)
        r_bubble_cnt <= r_bubble_cnt + CNT_ONE;
      if (w_op == OP_HOLD && r_hold_cnt != CNT_MAX)
        r_hold_cnt <= r_hold_cnt + CNT_ONE;
    end
  end

  assign bus.out_valid     = r_valid;
  assign bus.out_whilo     = r_whilo;
  assign bus.out_hi        = r_hi;
  assign bus.out_lo        = r_lo;
  assign bus.out_llbit_we  = r_llbit_we;
  assign bus.out_llbit_val = r_llbit_val;
  assign bus.last_op       = r_last_op;
  assign bus.bubble_cnt    = r_bubble_cnt;
  assign bus.hold_cnt      = r_hold_cnt;

endmodule
